// File: rtl/ysyx_22040125_pipe_pkg.sv
// Shared types and constants for the ysyx_22040125 flow-controlled pipeline register.
// The state encoding is {skid_valid, main_valid}, so bit 0 and bit 1 double as the valid flags.
package ysyx_22040125_pipe_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    localparam int                    PERF_CNT_W   = 32;
    localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = '1;

endpackage

// File: rtl/ysyx_22040125_sat_cnt.sv
// Saturating up-counter with enable; it sticks at all-ones instead of wrapping.
// It is used for the optional pipeline performance counters.
module ysyx_22040125_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != MAX)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ysyx_22040125_pipe_reg.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer, registered in_ready and flush.
// Optional stall/bubble counters are built only when PIPE_REG_PERF_EN is defined.
module ysyx_22040125_pipe_reg
    import ysyx_22040125_pipe_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush
`ifdef PIPE_REG_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] bubble_cnt
`endif
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              main_valid;
    logic              skid_valid;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    assign main_valid = state[0];
    assign skid_valid = state[1];

    // in_ready comes straight from a flop, so it has no combinational path from out_ready.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            next_state = S_EMPTY;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        next_state   = S_BUSY;
                        load_main_in = 1'b1;
                    end
                end
                S_BUSY: begin
                    if (in_fire && out_ready) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        next_state = S_FULL;
                        load_skid  = 1'b1;
                    end else if (out_fire) begin
                        next_state = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        next_state     = S_BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: next_state = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // The skid entry always moves into main before new input can land there, which keeps FIFO order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_REG_PERF_EN
    ysyx_22040125_sat_cnt #(
        .WIDTH(PERF_CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

    ysyx_22040125_sat_cnt #(
        .WIDTH(PERF_CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .en  (!out_valid),
        .cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_ysyx_22040125_pipe_reg.sv
// Directed and randomized self-checking bench for ysyx_22040125_pipe_reg (DATA_W=64, CLEAR_ON_FLUSH=1).
// Counter checks are compiled in when PIPE_REG_PERF_EN is defined; the saturating counter is also checked standalone.
module tb_ysyx_22040125_pipe_reg;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
`ifdef PIPE_REG_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif
    logic              sc_en;
    logic [3:0]        sc_cnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    ysyx_22040125_pipe_reg #(
        .DATA_W         (DATA_W),
        .CLEAR_ON_FLUSH (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush)
`ifdef PIPE_REG_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    ysyx_22040125_sat_cnt #(
        .WIDTH(4)
    ) u_sc (
        .clk (clk),
        .rst (rst),
        .en  (sc_en),
        .cnt (sc_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the random phase is cycle-bounded, this only catches a wedged simulation.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] q[$];
        int          delivered;
        int          cycles;
        logic        iv;
        logic        ordy;
        logic        fl;
        logic        inf;
        logic [63:0] d;

        rst   = 1'b1;
        sc_en = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        #12;
        checkOutput("reset_out_valid", 64'(out_valid), 64'h0);
        checkOutput("reset_out_data", out_data, 64'h0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'h1);
`ifdef PIPE_REG_PERF_EN
        checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'h0);
        checkOutput("reset_bubble_cnt", 64'(bubble_cnt), 64'h0);
`endif
        rst = 1'b0;

        $display("[TB] passthrough");
        applyStimulus(1'b1, 64'h1, 1'b1, 1'b0);
        tick();
        checkOutput("pass1_valid", 64'(out_valid), 64'h1);
        checkOutput("pass1_data", out_data, 64'h1);
        checkOutput("pass1_ready", 64'(in_ready), 64'h1);
        applyStimulus(1'b1, 64'h2, 1'b1, 1'b0);
        tick();
        checkOutput("pass2_data", out_data, 64'h2);
        checkOutput("pass2_ready", 64'(in_ready), 64'h1);
        applyStimulus(1'b1, 64'h3, 1'b1, 1'b0);
        tick();
        checkOutput("pass3_data", out_data, 64'h3);
        checkOutput("pass3_valid", 64'(out_valid), 64'h1);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("pass_drain_valid", 64'(out_valid), 64'h0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 64'hA, 1'b0, 1'b0);
        tick();
        checkOutput("bp_a_data", out_data, 64'hA);
        checkOutput("bp_a_ready", 64'(in_ready), 64'h1);
        applyStimulus(1'b1, 64'hB, 1'b0, 1'b0);
        tick();
        checkOutput("bp_full_ready", 64'(in_ready), 64'h0);
        checkOutput("bp_full_data", out_data, 64'hA);
        checkOutput("bp_full_valid", 64'(out_valid), 64'h1);
        applyStimulus(1'b1, 64'hBAD, 1'b0, 1'b0);
        tick();
        checkOutput("bp_hold_data", out_data, 64'hA);
        checkOutput("bp_hold_ready", 64'(in_ready), 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_b_data", out_data, 64'hB);
        checkOutput("bp_b_valid", 64'(out_valid), 64'h1);
        checkOutput("bp_b_ready", 64'(in_ready), 64'h1);
        tick();
        checkOutput("bp_empty_valid", 64'(out_valid), 64'h0);

        $display("[TB] flush");
        applyStimulus(1'b1, 64'h11, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'h22, 1'b0, 1'b0);
        tick();
        checkOutput("fl_pre_ready", 64'(in_ready), 64'h0);
        applyStimulus(1'b1, 64'hC, 1'b0, 1'b1);
        tick();
        checkOutput("fl_full_valid", 64'(out_valid), 64'h0);
        checkOutput("fl_full_ready", 64'(in_ready), 64'h1);
        checkOutput("fl_full_data", out_data, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("fl_after1_valid", 64'(out_valid), 64'h0);
        tick();
        checkOutput("fl_after2_valid", 64'(out_valid), 64'h0);
        applyStimulus(1'b1, 64'h33, 1'b1, 1'b0);
        tick();
        checkOutput("fl_busy_data", out_data, 64'h33);
        applyStimulus(1'b1, 64'h44, 1'b1, 1'b1);
        tick();
        checkOutput("fl_busy_valid", 64'(out_valid), 64'h0);
        checkOutput("fl_busy_data0", out_data, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("fl_busy_after", 64'(out_valid), 64'h0);

        $display("[TB] async reset");
        applyStimulus(1'b1, 64'h55, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("ar_busy_data", out_data, 64'h55);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("ar_valid", 64'(out_valid), 64'h0);
        checkOutput("ar_data", out_data, 64'h0);
        checkOutput("ar_ready", 64'(in_ready), 64'h1);
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 64'h66, 1'b1, 1'b0);
        tick();
        checkOutput("ar_accept_valid", 64'(out_valid), 64'h1);
        checkOutput("ar_accept_data", out_data, 64'h66);

`ifdef PIPE_REG_PERF_EN
        $display("[TB] performance counters");
        #3;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        applyStimulus(1'b1, 64'h77, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        repeat (5) tick();
        checkOutput("perf_stall5", 64'(stall_cnt), 64'd5);
        checkOutput("perf_bubble1", 64'(bubble_cnt), 64'd1);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        repeat (3) tick();
        checkOutput("perf_stall_keep", 64'(stall_cnt), 64'd5);
        checkOutput("perf_bubble4", 64'(bubble_cnt), 64'd4);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        checkOutput("perf_flush_stall", 64'(stall_cnt), 64'd5);
        checkOutput("perf_flush_bubble", 64'(bubble_cnt), 64'd5);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
`endif

        $display("[TB] saturating counter");
        #3;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        checkOutput("sat_reset", 64'(sc_cnt), 64'd0);
        sc_en = 1'b1;
        repeat (14) tick();
        checkOutput("sat_14", 64'(sc_cnt), 64'd14);
        tick();
        checkOutput("sat_max", 64'(sc_cnt), 64'd15);
        repeat (3) tick();
        checkOutput("sat_hold", 64'(sc_cnt), 64'd15);
        sc_en = 1'b0;

        $display("[TB] random traffic");
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        delivered = 0;
        cycles    = 0;
        while (delivered < 10000 && cycles < 60000) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 63) == 0);
            d    = {$urandom, $urandom};
            applyStimulus(iv, d, ordy, fl);
            inf = iv && in_ready;
            if (out_valid && ordy) begin
                if (q.size() == 0) begin
                    checkOutput("rand_spurious", 64'(out_valid), 64'h0);
                end else begin
                    checkOutput("rand_order", out_data, q[0]);
                    void'(q.pop_front());
                end
                delivered++;
            end
            tick();
            cycles++;
            if (fl) begin
                q.delete();
                checkOutput("rand_flush_clear", out_data, 64'h0);
            end else if (inf) begin
                q.push_back(d);
            end
            checkOutput("rand_valid", 64'(out_valid), 64'(q.size() != 0));
            checkOutput("rand_ready", 64'(in_ready), 64'(q.size() < 2));
            if (out_valid && q.size() != 0) begin
                checkOutput("rand_data", out_data, q[0]);
            end
        end
        checkOutput("rand_delivered", 64'(delivered), 64'd10000);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
